// File: rtl/vend_pkg.sv
// Shared types and coin values for the vending accept and change-dispense FSMs.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    WAIT_SEEN,
    DONE
  } disp_state_t;

  localparam int COIN1_VAL = 1;
  localparam int COIN2_VAL = 2;

endpackage

// File: rtl/disp_timer.sv
// Loadable down-counter shared by the eject pulse length and the coin-seen timeout.
module disp_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Loading len gives len+1 cycles until expired, counted in enabled cycles only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (start) begin
        cnt <= len;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: greedy 2/1 rupee coin selection, timed eject pulses,
// exit-sensor confirmation with jam timeout, and per-denomination inventory.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W       = 4,
  parameter int INV_W       = 6,
  parameter int PULSE_CYC   = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             load,
  input  logic [INV_W-1:0] load_cnt1,
  input  logic [INV_W-1:0] load_cnt2,
  output logic             eject1,
  output logic             eject2,
  input  logic             coin_seen,
  output logic             done,
  output logic             short,
  output logic             jam,
  output logic [AMT_W-1:0] remaining,
  output logic [INV_W-1:0] inv1,
  output logic [INV_W-1:0] inv2
);

  localparam int TMAX  = (PULSE_CYC > ACK_TIMEOUT) ? PULSE_CYC : ACK_TIMEOUT;
  localparam int CNT_W = $clog2(TMAX + 1);

  disp_state_t      state;
  logic [AMT_W-1:0] rem;
  logic             coin2;
  logic             take1;
  logic             take2;
  logic             timer_start;
  logic [CNT_W-1:0] timer_len;
  logic             expired;

  assign take2 = (rem >= AMT_W'(COIN2_VAL)) && (inv2 != '0);
  assign take1 = !take2 && (rem >= AMT_W'(COIN1_VAL)) && (inv1 != '0);

  assign req_ready = (state == IDLE) && !load;

  // The timer is armed for the pulse when a coin is chosen, and re-armed for the
  // timeout on the last pulse cycle so both windows start on state entry.
  assign timer_start = ((state == SELECT) && (take1 || take2)) ||
                       ((state == EJECT) && expired);
  assign timer_len   = (state == SELECT) ? CNT_W'(PULSE_CYC - 1) : CNT_W'(ACK_TIMEOUT - 1);

  disp_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .start  (timer_start),
    .len    (timer_len),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      coin2     <= 1'b0;
      inv1      <= '0;
      inv2      <= '0;
      eject1    <= 1'b0;
      eject2    <= 1'b0;
      done      <= 1'b0;
      short     <= 1'b0;
      jam       <= 1'b0;
      remaining <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (load) begin
            inv1 <= load_cnt1;
            inv2 <= load_cnt2;
          end else if (req_valid) begin
            rem       <= req_amount;
            short     <= 1'b0;
            jam       <= 1'b0;
            remaining <= '0;
            state     <= SELECT;
          end
        end
        SELECT: begin
          if (take2) begin
            inv2   <= inv2 - INV_W'(1);
            coin2  <= 1'b1;
            eject2 <= 1'b1;
            state  <= EJECT;
          end else if (take1) begin
            inv1   <= inv1 - INV_W'(1);
            coin2  <= 1'b0;
            eject1 <= 1'b1;
            state  <= EJECT;
          end else begin
            short     <= (rem != '0);
            remaining <= rem;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        EJECT: begin
          if (expired) begin
            eject1 <= 1'b0;
            eject2 <= 1'b0;
            state  <= WAIT_SEEN;
          end
        end
        WAIT_SEEN: begin
          // A stuck coin stays deducted from inventory but not from the amount owed.
          if (coin_seen) begin
            rem   <= rem - (coin2 ? AMT_W'(COIN2_VAL) : AMT_W'(COIN1_VAL));
            state <= SELECT;
          end else if (expired) begin
            jam       <= 1'b1;
            remaining <= rem;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a greedy payout / timeline model.
module tb_change_dispenser;

  localparam int AMT_W = 4;
  localparam int INV_W = 6;
  localparam int P     = 4;
  localparam int A     = 15;

  logic             clk        = 1'b0;
  logic             rst_n      = 1'b0;
  logic             ena        = 1'b0;
  logic             req_valid  = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_ready;
  logic             load       = 1'b0;
  logic [INV_W-1:0] load_cnt1  = '0;
  logic [INV_W-1:0] load_cnt2  = '0;
  logic             eject1;
  logic             eject2;
  logic             coin_seen  = 1'b0;
  logic             done;
  logic             short;
  logic             jam;
  logic [AMT_W-1:0] remaining;
  logic [INV_W-1:0] inv1;
  logic [INV_W-1:0] inv2;

  int n_cmp  = 0;
  int n_err  = 0;
  int m_inv1 = 0;
  int m_inv2 = 0;

  always #5 clk = ~clk;

  change_dispenser #(
    .AMT_W      (AMT_W),
    .INV_W      (INV_W),
    .PULSE_CYC  (P),
    .ACK_TIMEOUT(A)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req_valid (req_valid),
    .req_amount(req_amount),
    .req_ready (req_ready),
    .load      (load),
    .load_cnt1 (load_cnt1),
    .load_cnt2 (load_cnt2),
    .eject1    (eject1),
    .eject2    (eject2),
    .coin_seen (coin_seen),
    .done      (done),
    .short     (short),
    .jam       (jam),
    .remaining (remaining),
    .inv1      (inv1),
    .inv2      (inv2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_load(input int c1, input int c2, input int with_req);
    @(negedge clk);
    ena       = 1'b1;
    load      = 1'b1;
    load_cnt1 = INV_W'(c1);
    load_cnt2 = INV_W'(c2);
    req_valid = (with_req != 0);
    #1 chk("ready_vs_load", 32'(req_ready), 0);
    @(negedge clk);
    load      = 1'b0;
    req_valid = 1'b0;
    m_inv1    = c1;
    m_inv2    = c2;
    #1;
    chk("inv1_load", 32'(inv1), m_inv1);
    chk("inv2_load", 32'(inv2), m_inv2);
  endtask

  // Model: greedy coin list from plain arithmetic, then a per-enabled-cycle
  // timeline of {req_ready, done, eject2, eject1} and the coin_seen drive.
  task automatic run_req(input int amt, input int jam_at, input int fix_d, input int ena_pct,
                         input int hold_at, input int hold_n, output int c1, output int c2);
    logic [3:0] eo[$];
    bit         cs[$];
    int         coins[$];
    int         n2, n1, rest, e_rem, k, guard, hold_left, d;
    bit         e_short, e_jam, en;
    n2   = (amt / 2 < m_inv2) ? amt / 2 : m_inv2;
    rest = amt - 2 * n2;
    n1   = (rest < m_inv1) ? rest : m_inv1;
    repeat (n2) coins.push_back(2);
    repeat (n1) coins.push_back(1);
    e_rem   = rest - n1;
    e_short = (e_rem != 0);
    e_jam   = 1'b0;
    if (jam_at >= 0 && jam_at < coins.size()) begin
      e_jam   = 1'b1;
      e_short = 1'b0;
      e_rem   = amt;
      for (int j = 0; j < jam_at; j++) e_rem -= coins[j];
      while (coins.size() > jam_at + 1) void'(coins.pop_back());
    end
    foreach (coins[j]) begin
      if (coins[j] == 2) m_inv2--;
      else m_inv1--;
    end
    eo.push_back(4'b1000); cs.push_back(1'b0);
    eo.push_back(4'b0000); cs.push_back(1'b0);
    foreach (coins[j]) begin
      for (int p = 0; p < P; p++) begin
        eo.push_back(coins[j] == 2 ? 4'b0010 : 4'b0001);
        cs.push_back($urandom_range(0, 3) == 0);
      end
      if (e_jam && j == coins.size() - 1) begin
        repeat (A) begin eo.push_back(4'b0000); cs.push_back(1'b0); end
      end else begin
        d = (fix_d >= 0) ? fix_d : $urandom_range(0, A - 1);
        for (int i = 0; i <= d; i++) begin eo.push_back(4'b0000); cs.push_back(i == d); end
        eo.push_back(4'b0000); cs.push_back(1'b0);
      end
    end
    eo.push_back(4'b0100); cs.push_back(1'b0);
    eo.push_back(4'b1000); cs.push_back(1'b0);

    k = 0; guard = 0; hold_left = hold_n; c1 = 0; c2 = 0;
    while (k < eo.size() && guard < 3000) begin
      if (k == 0) en = 1'b1;
      else if (k == hold_at && hold_left > 0) begin en = 1'b0; hold_left--; end
      else en = ($urandom_range(0, 99) >= ena_pct);
      ena        = en;
      req_valid  = (k == 0);
      req_amount = AMT_W'(amt);
      coin_seen  = cs[k];
      load       = (k > 0) && (k < eo.size() - 1) && ($urandom_range(0, 7) == 0);
      load_cnt1  = INV_W'($urandom);
      load_cnt2  = INV_W'($urandom);
      #1;
      chk("outs", 32'({req_ready, done, eject2, eject1}), 32'(eo[k]));
      if (k == 1) chk("status_clr", 32'({short, jam, remaining}), 0);
      if (eo[k][2]) begin
        chk("status_done", 32'({short, jam, remaining}), 32'({e_short, e_jam, AMT_W'(e_rem)}));
        chk("inv1_done", 32'(inv1), m_inv1);
        chk("inv2_done", 32'(inv2), m_inv2);
      end
      if (eject1) c1++;
      if (eject2) c2++;
      @(negedge clk);
      if (en) k++;
      guard++;
    end
    chk("req_finished", 32'(k), 32'(eo.size()));
    ena = 1'b1; load = 1'b0; coin_seen = 1'b0; req_valid = 1'b0;
  endtask

  task automatic reset_mid_eject();
    int g;
    ena        = 1'b1;
    req_amount = AMT_W'(3);
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    g = 0;
    while (!eject2 && g < 10) begin @(negedge clk); g++; end
    chk("rst_reach_eject", 32'(eject2), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_eject_drop", 32'({eject2, eject1}), 0);
    chk("rst_inv", 32'({inv2, inv1}), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_inv1 = 0;
    m_inv2 = 0;
    #1 chk("rst_ready", 32'(req_ready), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2;
    #12;
    chk("rst_outs", 32'({req_ready, done, eject2, eject1}), 32'h8);
    chk("rst_status", 32'({short, jam, remaining}), 0);
    chk("rst_inv0", 32'({inv2, inv1}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;

    do_load(5, 5, 0);
    run_req(3, -1, 1, 0, -1, 0, c1, c2);
    chk("normal_e2_len", c2, P);
    chk("normal_e1_len", c1, P);

    do_load(2, 0, 0);
    run_req(3, -1, -1, 0, -1, 0, c1, c2);
    chk("short_e1_len", c1, 2 * P);
    chk("short_e2_len", c2, 0);

    run_req(0, -1, -1, 0, -1, 0, c1, c2);
    chk("zero_no_eject", c1 + c2, 0);

    do_load(5, 5, 0);
    run_req(2, 0, -1, 0, -1, 0, c1, c2);
    chk("jam_e2_len", c2, P);

    do_load(3, 4, 1);
    run_req(5, -1, -1, 0, -1, 0, c1, c2);

    do_load(5, 5, 0);
    run_req(2, -1, 0, 0, 3, 3, c1, c2);
    chk("ena_hold_pulse", c2, P + 3);

    repeat (40) begin
      if ($urandom_range(0, 2) == 0)
        do_load($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1));
      run_req($urandom_range(0, 15), ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1,
              -1, 10, -1, 0, c1, c2);
    end

    do_load(5, 5, 0);
    reset_mid_eject();
    run_req(0, -1, -1, 0, -1, 0, c1, c2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
